// File: rtl/vjtag_mailbox_if.sv
// Word-level handshake bundle between the vJTAG mailbox and the user design.
// The mailbox takes the slave modport; the user design takes the master modport.
interface vjtag_mailbox_if #(
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0] h2d_data;
  logic              h2d_valid;
  logic              h2d_ready;
  logic [DATA_W-1:0] d2h_data;
  logic              d2h_valid;
  logic              d2h_ready;

  modport master (
    input  h2d_data,
    input  h2d_valid,
    output h2d_ready,
    output d2h_data,
    output d2h_valid,
    input  d2h_ready
  );

  modport slave (
    output h2d_data,
    output h2d_valid,
    input  h2d_ready,
    input  d2h_data,
    input  d2h_valid,
    output d2h_ready
  );
endinterface

// File: rtl/vjtag_mailbox.sv
// Virtual-JTAG user responder: STATUS/DATA data registers on tck, bridging a
// host-to-device FIFO and a device-to-host holding register.
module vjtag_mailbox #(
  parameter int DATA_W = 32,  // >= 8
  parameter int DEPTH  = 4    // power of two, 2..8
) (
  input  logic tck,
  input  logic rst_n,
  input  logic tdi,
  output logic tdo,
  input  logic ir_in,
  output logic ir_out,
  input  logic virtual_state_cdr,
  input  logic virtual_state_sdr,
  input  logic virtual_state_udr,
  vjtag_mailbox_if.slave mbx
);

  localparam int SR_W  = DATA_W + 1;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef enum logic {
    IR_STATUS = 1'b0,
    IR_DATA   = 1'b1
  } ir_sel_e;

  ir_sel_e ir_sel;
  assign ir_sel = ir_sel_e'(ir_in);

  logic [SR_W-1:0]   sr_q, sr_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic              hold_valid_q, hold_valid_d;
  logic              overflow_q, overflow_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic       fifo_full, fifo_empty;
  logic       push_req, push, pop, ovf_set, ovf_clr, d2h_fire;
  logic [3:0] count4;
  logic [7:0] status_word;

  assign fifo_full   = (count_q == CNT_W'(DEPTH));
  assign fifo_empty  = (count_q == '0);
  assign count4      = 4'(count_q);
  assign status_word = {count4, overflow_q, fifo_empty, fifo_full, hold_valid_q};

  // NOTE: every signal driven here gets a default first, so no path through
  // the block leaves a value unassigned and no latch is inferred.
  always_comb begin
    sr_d         = sr_q;
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    overflow_d   = overflow_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    push_req     = 1'b0;
    ovf_clr      = 1'b0;

    // Strobes are mutually exclusive in legal use; CDR > UDR > SDR otherwise.
    if (virtual_state_cdr) begin
      if (ir_sel == IR_DATA) begin
        // Destructive read: the capture itself frees the holding register.
        sr_d         = hold_valid_q ? {hold_q, 1'b1} : '0;
        hold_valid_d = 1'b0;
      end else begin
        sr_d      = '0;
        sr_d[7:0] = status_word;
      end
    end else if (virtual_state_udr) begin
      if (ir_sel == IR_DATA) push_req = sr_q[0];
      else                   ovf_clr  = sr_q[3];
    end else if (virtual_state_sdr) begin
      if (ir_sel == IR_DATA) begin
        sr_d = {tdi, sr_q[SR_W-1:1]};
      end else begin
        sr_d      = '0;
        sr_d[7]   = tdi;
        sr_d[6:0] = sr_q[7:1];
      end
    end

    // Loading only when empty means it can never collide with the CDR clear.
    d2h_fire = mbx.d2h_valid && !hold_valid_q;
    if (d2h_fire) begin
      hold_d       = mbx.d2h_data;
      hold_valid_d = 1'b1;
    end

    // Fullness is judged before any same-cycle pop.
    pop     = !fifo_empty && mbx.h2d_ready;
    push    = push_req && !fifo_full;
    ovf_set = push_req && fifo_full;

    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);

    if (ovf_set)      overflow_d = 1'b1;
    else if (ovf_clr) overflow_d = 1'b0;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, regardless of statement order.
  always_ff @(posedge tck or negedge rst_n) begin
    if (!rst_n) begin
      sr_q         <= '0;
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
    end else begin
      sr_q         <= sr_d;
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
      overflow_q   <= overflow_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
    end
  end

  // NOTE: FIFO storage has no reset; validity is tracked by count/pointers,
  // which keeps the array mappable onto plain RAM or unreset flops.
  always_ff @(posedge tck) begin
    if (push) mem_q[wr_ptr_q] <= sr_q[SR_W-1:1];
  end

  assign tdo           = sr_q[0];
  assign ir_out        = hold_valid_q;
  assign mbx.h2d_valid = !fifo_empty;
  assign mbx.h2d_data  = fifo_empty ? '0 : mem_q[rd_ptr_q];
  assign mbx.d2h_ready = !hold_valid_q;

endmodule

// File: doc/vjtag_mailbox.md
# vjtag_mailbox

User-side responder for the Intel virtual JTAG hub. It sits behind the vJTAG instance and is clocked on its `tck`. It interprets the virtual DR states to implement two host-visible data registers: a STATUS register and a DATA register. It exchanges words with the design through a host-to-device FIFO and a device-to-host holding register, both with valid/ready handshakes in the `tck` domain.

## Interface
- `DATA_W`, 32: mailbox word width; must be ≥ 8.
- `DEPTH`, 4: host-to-device FIFO entries; power of two, 2..8.

- `tck`  in  1  clock from the vJTAG hub; all logic is on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `tdi`  in  1  serial data from the hub.
- `tdo`  out  1  serial data to the hub.
- `ir_in`  in  1  virtual IR: 0 selects STATUS, 1 selects DATA.
- `ir_out`  out  1  value captured into the virtual IR; equals `hold_valid`.
- `virtual_state_cdr`  in  1  capture-DR strobe.
- `virtual_state_sdr`  in  1  shift-DR strobe.
- `virtual_state_udr`  in  1  update-DR strobe.
- `h2d_data`  out  DATA_W  FIFO head.
- `h2d_valid`  out  1  FIFO not empty.
- `h2d_ready`  in  1  design pops the head.
- `d2h_data`  in  DATA_W  word offered to the host.
- `d2h_valid`  in  1  offer valid.
- `d2h_ready`  out  1  high when the holding register is empty (`!hold_valid`).

## Operation
- Shift register `sr`, DATA_W+1 bits. `tdo = sr[0]` (combinational).
- DR length depends on the selected IR:
  - DATA: DATA_W+1 bits.
  - STATUS: 8 bits.
- On `virtual_state_sdr`: shift LSB-first. `tdi` enters at bit (len−1) of the active length; bits above the length hold 0.
- CDR, DATA selected:
  - `sr <= {hold, hold_valid}`, so bit0 is the valid flag.
  - If `hold_valid` was 1, clear it. The read is destructive at capture.
  - If `hold_valid` was 0, the data field is 0.
- CDR, STATUS selected: `sr[7:0] <= {count[3:0], overflow, fifo_empty, fifo_full, hold_valid}`, with bit0 = `hold_valid`.
- UDR, DATA selected: bit0 of the shifted frame is the write strobe.
  - Strobe 1, FIFO not full: push `sr[DATA_W:1]`.
  - Strobe 1, FIFO full: drop the word and set `overflow`.
  - Strobe 0: no effect.
- UDR, STATUS selected: if shifted `sr[3]` is 1, clear `overflow`. Other bits are ignored.
- `ir_in` is sampled on the same edge as each CDR/UDR strobe.
- Device-to-host path: on `d2h_valid && d2h_ready`, load `hold <= d2h_data` and set `hold_valid`.
- Host-to-device FIFO: pop on `h2d_valid && h2d_ready`. `count` ranges 0..DEPTH; pointers wrap modulo DEPTH.
- Push and pop in the same cycle:
  - FIFO not full: both happen; `count` is unchanged.
  - FIFO full: the push is dropped with `overflow`, even if a pop occurs in the same cycle (fullness is evaluated pre-pop); the pop still happens.
- Only one of CDR/SDR/UDR is high in any cycle; precedence if violated: CDR > UDR > SDR.
- Reset values:
  - `sr`, `hold`, `hold_valid`, `overflow`, pointers, `count`: all 0.
  - Outputs: `tdo` = 0, `ir_out` = 0, `h2d_valid` = 0, `h2d_data` = 0, `d2h_ready` = 1.
  - FIFO storage contents are unspecified.
- Reset mid-shift aborts the frame; no push occurs.

## Timing
- `tdo` updates after each rising edge where SDR or CDR is high.
- UDR push: `h2d_valid` rises on the edge following the UDR edge (1-cycle latency).
- CDR consume: `d2h_ready` rises on the edge after the CDR edge. A new word can be loaded on the following edge.
- Handshakes are standard valid/ready. Transfer occurs on a rising edge where both are high. `d2h_data` is sampled only then.
- `overflow` set and clear take effect on the UDR edge itself. If set and clear coincide, set wins; they cannot coincide in legal operation.

## Test plan
- Reset released, STATUS selected, CDR followed by 8 SDR cycles → `tdo` stream LSB-first 0,0,1,0,0,0,0,0 (empty=1, count=0).
- DATA selected, shift 33 bits (strobe=1, data 0xDEADBEEF), then UDR → `h2d_valid` = 1 one cycle later, `h2d_data` = 0xDEADBEEF; `h2d_ready` pulse → `h2d_valid` = 0.
- Push 5 words with `h2d_ready` = 0 (DEPTH=4) → FIFO full; 5th word dropped; STATUS read shows count=4, full=1, overflow=1. Shifting STATUS with bit3=1 then UDR → overflow=0.
- Design offers `d2h_data` = 0x12345678 → `d2h_ready` drops, `ir_out` = 1. DATA CDR + 33 SDR → `tdo` emits 1 then 0x12345678 LSB-first; `d2h_ready` = 1 the cycle after CDR. An immediate second CDR returns bit0 = 0 and data 0.
- FIFO full with simultaneous pop and UDR push → pop occurs, push dropped, overflow set, count = 3.
- `rst_n` asserted after 10 of 33 SDR cycles → all outputs at reset values asynchronously; no push after release.
